wave_ctrl: RTL

Sequencing controller for the four-waveform ROM generator (sin, square, sawtooth, triangular).
- Consumes debounced key negedge pulses, one each for waveform, frequency and amplitude.
- Runs a phase accumulator that drives the shared ROM address and rden.
- Selects and amplitude-scales the active ROM output.
- Mutes the output to mid-scale for a fixed window on every waveform switch, so the DAC sees no glitch.
- Sits between the ax_debounce instances and the DAC output pin dout.

---
 rtl/wave_ctrl_if.sv | 31 +++
 rtl/wave_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wave_ctrl_if.sv
// Shared waveform-ROM bus: one address/read-enable fanned out to four ROMs,
// each returning its sample one clock after the address.
interface wave_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rden;
  logic [DATA_W-1:0] sin_q;
  logic [DATA_W-1:0] square_q;
  logic [DATA_W-1:0] sawtooth_q;
  logic [DATA_W-1:0] triangular_q;

  modport master (
    output rom_addr,
    output rom_rden,
    input  sin_q,
    input  square_q,
    input  sawtooth_q,
    input  triangular_q
  );

  modport slave (
    input  rom_addr,
    input  rom_rden,
    output sin_q,
    output square_q,
    output sawtooth_q,
    output triangular_q
  );
endinterface

// File: rtl/wave_ctrl.sv
// Waveform sequencer: phase accumulator -> ROM address, then select + amplitude-scale the sample.
// Latency: 2 clocks from rom_addr to o_dout; no backpressure, key pulses are always accepted.
module wave_ctrl #(
  parameter int ACC_W       = 24,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int FSTEP_BASE  = 65536,
  parameter int MUTE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_sel_pulse,
  input  logic              i_freq_pulse,
  input  logic              i_amp_pulse,
  wave_ctrl_if.master       rom,
  output logic [DATA_W-1:0] o_dout,
  output logic [1:0]        o_wave_sel,
  output logic [2:0]        o_freq_idx,
  output logic [1:0]        o_amp_idx,
  output logic              o_muted
);

  localparam int CNT_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  MCNT_LAST = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUTE = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_phase;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rden;
  logic [CNT_W-1:0]   r_mcnt;
  logic [1:0]         r_wsel;
  logic [2:0]         r_fidx;
  logic [1:0]         r_aidx;
  logic [1:0]         r_wsel_d1;
  logic [1:0]         r_wsel_d2;
  logic [1:0]         r_aidx_d1;
  logic [1:0]         r_aidx_d2;
  logic               r_src_d1;
  logic               r_src_d2;
  logic [DATA_W-1:0]  r_dout;
  logic               r_muted;

  state_t             w_nxt;
  logic               w_run_nxt;
  logic               w_phase_clr;
  logic [ACC_W-1:0]   w_step;
  logic [ACC_W-1:0]   w_phase_nxt;
  logic [DATA_W-1:0]  w_sample;
  logic signed [DATA_W-1:0] w_s;
  logic signed [DATA_W-1:0] w_t;
  logic [DATA_W-1:0]  w_scaled;
  logic               w_out_vld;

  // enable low wins over everything; a sel pulse inside MUTE keeps us there
  always_comb begin
    w_nxt = r_state;
    if (!i_enable) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_nxt = ST_RUN;
        ST_RUN:  if (i_sel_pulse) w_nxt = ST_MUTE;
        ST_MUTE: if (!i_sel_pulse && (r_mcnt == MCNT_LAST)) w_nxt = ST_RUN;
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_run_nxt   = (w_nxt == ST_RUN);
  assign w_step      = ACC_W'(FSTEP_BASE) << r_fidx;
  assign w_phase_clr = (w_nxt == ST_IDLE) || (r_state == ST_IDLE) ||
                       ((r_state == ST_RUN) && (w_nxt == ST_MUTE));
  assign w_phase_nxt = w_phase_clr ? '0 : (r_phase + w_step);

  always_comb begin
    w_sample = rom.sin_q;
    case (r_wsel_d2)
      2'd0:    w_sample = rom.sin_q;
      2'd1:    w_sample = rom.square_q;
      2'd2:    w_sample = rom.sawtooth_q;
      default: w_sample = rom.triangular_q;
    endcase
  end

  // offset-binary -> two's complement, attenuate around mid-scale, and back
  assign w_s      = $signed(w_sample ^ MID);
  assign w_t      = w_s >>> r_aidx_d2;
  assign w_scaled = $unsigned(w_t) ^ MID;

  // a sample reaches the DAC only if it was fetched in RUN and we are staying in RUN
  assign w_out_vld = r_src_d2 && w_run_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_addr    <= '0;
      r_rden    <= 1'b0;
      r_mcnt    <= '0;
      r_wsel    <= 2'd0;
      r_fidx    <= 3'd0;
      r_aidx    <= 2'd0;
      r_wsel_d1 <= 2'd0;
      r_wsel_d2 <= 2'd0;
      r_aidx_d1 <= 2'd0;
      r_aidx_d2 <= 2'd0;
      r_src_d1  <= 1'b0;
      r_src_d2  <= 1'b0;
      r_dout    <= MID;
      r_muted   <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_phase <= w_phase_nxt;
      r_addr  <= w_phase_nxt[ACC_W-1 -: ADDR_W];
      r_rden  <= (w_nxt != ST_IDLE);

      if ((w_nxt == ST_MUTE) && (r_state == ST_MUTE) && !i_sel_pulse) begin
        r_mcnt <= r_mcnt + CNT_W'(1);
      end else begin
        r_mcnt <= '0;
      end

      if (i_sel_pulse)  r_wsel <= r_wsel + 2'd1;
      if (i_freq_pulse) r_fidx <= r_fidx + 3'd1;
      if (i_amp_pulse)  r_aidx <= r_aidx + 2'd1;

      r_wsel_d1 <= r_wsel;
      r_wsel_d2 <= r_wsel_d1;
      r_aidx_d1 <= r_aidx;
      r_aidx_d2 <= r_aidx_d1;

      r_src_d1  <= w_run_nxt;
      r_src_d2  <= r_src_d1 && w_run_nxt;
      r_dout    <= w_out_vld ? w_scaled : MID;
      r_muted   <= !w_out_vld;
    end
  end

  assign rom.rom_addr = r_addr;
  assign rom.rom_rden = r_rden;
  assign o_dout       = r_dout;
  assign o_wave_sel   = r_wsel;
  assign o_freq_idx   = r_fidx;
  assign o_amp_idx    = r_aidx;
  assign o_muted      = r_muted;

endmodule
